// File: rtl/spi_tx_feeder_if.sv
// Producer write channel plus the feeder-to-SPI-master request channel.
// The slave modport is the feeder's view; master is the producer/SPI side.
interface spi_tx_feeder_if #(
   parameter int WIDTH = 12
);
   logic             wr_valid;
   logic [WIDTH-1:0] wr_data;
   logic             wr_ready;
   logic             flush;
   logic             cs_in;
   logic             newd;
   logic [WIDTH-1:0] din;

   modport slave  (input  wr_valid, wr_data, flush, cs_in,
                   output wr_ready, newd, din);
   modport master (output wr_valid, wr_data, flush, cs_in,
                   input  wr_ready, newd, din);
endinterface

// File: rtl/spi_tx_feeder.sv
// FIFO-backed word feeder for the SPI master: pops one word per frame and
// paces requests off the master's chip select with a fixed inter-frame gap.
module spi_tx_feeder #(
   parameter int WIDTH      = 12,
   parameter int DEPTH      = 8,
   parameter int GAP_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   spi_tx_feeder_if.slave        bus,
   output logic                  busy,
   output logic [$clog2(DEPTH):0] level,
   output logic                  word_done
);
   localparam int AW    = $clog2(DEPTH);
   localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int GLAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] REQ   = 2'd1;
   localparam logic [1:0] FRAME = 2'd2;
   localparam logic [1:0] GAP   = 2'd3;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr, rptr;
   logic             full, empty, wr_en, pop;
   logic [1:0]       state;
   logic [GW-1:0]    gcnt;
   logic             cs_q;

   assign empty        = (wptr == rptr);
   assign full         = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign bus.wr_ready = !full && !bus.flush;
   assign wr_en        = bus.wr_valid && bus.wr_ready;
   // A flush in IDLE wins over a pop so the cleared FIFO never leaks a word.
   assign pop          = (state == IDLE) && !empty && !bus.flush;
   assign level        = wptr - rptr;
   assign busy         = (state != IDLE);

   always_ff @(posedge clk) begin
      if (wr_en) mem[wptr[AW-1:0]] <= bus.wr_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr <= '0;
         rptr <= '0;
      end else if (bus.flush) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr_en) wptr <= wptr + 1'b1;
         if (pop)   rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cs_q      <= 1'b1;
         bus.newd  <= 1'b0;
         bus.din   <= '0;
         word_done <= 1'b0;
         gcnt      <= '0;
      end else begin
         cs_q      <= bus.cs_in;
         word_done <= 1'b0;
         case (state)
            IDLE: if (pop) begin
               bus.din  <= mem[rptr[AW-1:0]];
               bus.newd <= 1'b1;
               state    <= REQ;
            end
            REQ: if (!cs_q) begin
               bus.newd <= 1'b0;
               state    <= FRAME;
            end
            FRAME: if (cs_q) begin
               word_done <= 1'b1;
               gcnt      <= '0;
               state     <= (GAP_CYCLES == 0) ? IDLE : GAP;
            end
            GAP: begin
               if (gcnt == GW'(GLAST)) state <= IDLE;
               else                    gcnt  <= gcnt + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_tx_feeder.sv
// Bench for spi_tx_feeder: behavioural SPI-master cs model, directed stimulus,
// and a scoreboard monitor that checks every word the feeder presents.
module tb_spi_tx_feeder;
   localparam int W  = 12;
   localparam int D  = 8;
   localparam int G  = 4;
   localparam int FL = 12;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic busy, word_done;
   logic [$clog2(D):0] level;

   spi_tx_feeder_if #(.WIDTH(W)) bus ();

   spi_tx_feeder #(.WIDTH(W), .DEPTH(D), .GAP_CYCLES(G)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .busy(busy), .level(level), .word_done(word_done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   logic [W-1:0] expq[$];
   int cyc = 0, wd_cnt = 0, wd_cyc = 0;
   bit have_wd = 1'b0, chk_gap = 1'b0;
   logic newd_d = 1'b0;
   int ms = 0, mcnt = 0, t = 0, wd0 = 0;
   logic [W-1:0] lat = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every newd rise is one presented word.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst) begin
            newd_d  = 1'b0;
            have_wd = 1'b0;
         end else begin
            if (word_done) begin
               wd_cnt++;
               wd_cyc  = cyc;
               have_wd = 1'b1;
            end
            if (bus.newd && !newd_d) begin
               if (expq.size() == 0) check("unexpected_newd", 32'd1, 32'd0);
               else                  check("din_order", 32'(bus.din), 32'(expq.pop_front()));
               if (have_wd && chk_gap) check("gap_edges", 32'(cyc - wd_cyc), 32'(G + 1));
               have_wd = 1'b0;
            end
            newd_d = bus.newd;
         end
      end
   end

   // SPI master cs model: a few cycles of latency, then a FL-cycle frame.
   initial begin
      bus.cs_in = 1'b1;
      forever begin
         @(negedge clk);
         if (!rst) begin
            ms = 0; mcnt = 0; bus.cs_in = 1'b1;
         end else begin
            case (ms)
               0: if (bus.newd) begin lat = bus.din; mcnt = 0; ms = 1; end
               1: begin
                  mcnt++;
                  if (mcnt == 3) begin bus.cs_in = 1'b0; mcnt = 0; ms = 2; end
               end
               2: begin
                  mcnt++;
                  if (mcnt == 1) check("newd_hold", 32'(bus.newd), 32'd1);
                  if (mcnt == 2) check("newd_fall", 32'(bus.newd), 32'd0);
                  if (mcnt == FL) begin
                     check("din_stable", 32'(bus.din), 32'(lat));
                     bus.cs_in = 1'b1;
                     ms = 0;
                  end
               end
               default: ms = 0;
            endcase
         end
      end
   end

   task automatic put(input logic [W-1:0] d);
      int k = 0;
      bus.wr_data  = d;
      bus.wr_valid = 1'b1;
      #1;
      while (!bus.wr_ready && k < 500) begin @(negedge clk); #1; k++; end
      if (k >= 500) check("put_timeout", 32'd0, 32'd1);
      else          expq.push_back(d);
      @(negedge clk);
   endtask

   task automatic drain(input string name);
      int k = 0;
      while ((expq.size() != 0 || busy) && k < 2000) begin @(negedge clk); k++; end
      check(name, 32'(k < 2000), 32'd1);
   endtask

   task automatic wait_frame();
      int k = 0;
      while (bus.cs_in && k < 200) begin @(negedge clk); k++; end
      check("frame_start", 32'(k < 200), 32'd1);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 12'h123;
      bus.flush    = 1'b0;

      // reset held with a pending write
      repeat (3) @(negedge clk);
      check("rst_newd", 32'(bus.newd), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_din", 32'(bus.din), 32'd0);
      check("rst_word_done", 32'(word_done), 32'd0);
      check("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
      expq.push_back(12'h123);
      rst = 1'b1;
      @(negedge clk);
      bus.wr_valid = 1'b0;
      check("rel_level", 32'(level), 32'd1);
      check("rel_newd", 32'(bus.newd), 32'd0);
      @(negedge clk);
      check("rel_pop_newd", 32'(bus.newd), 32'd1);
      check("rel_pop_level", 32'(level), 32'd0);
      drain("drain_reset");

      // single word
      wd0 = wd_cnt;
      put(12'hA5C);
      bus.wr_valid = 1'b0;
      drain("drain_single");
      check("single_word_done", 32'(wd_cnt - wd0), 32'd1);

      // burst of nine with valid held high
      wd0 = wd_cnt;
      for (int i = 1; i <= 9; i++) put(12'(i));
      check("burst_level", 32'(level), 32'd8);
      check("burst_wr_ready", 32'(bus.wr_ready), 32'd0);
      check("burst_busy", 32'(busy), 32'd1);
      chk_gap = 1'b1;

      // full FIFO: write refused on the pop edge, accepted one edge later
      bus.wr_data = 12'h00A;
      #1;
      t = 0;
      while (!bus.wr_ready && t < 500) begin @(negedge clk); #1; t++; end
      check("full_pop_level", 32'(level), 32'd7);
      expq.push_back(12'h00A);
      @(negedge clk);
      bus.wr_valid = 1'b0;
      check("full_accept_level", 32'(level), 32'd8);
      drain("drain_burst");
      check("burst_word_done", 32'(wd_cnt - wd0), 32'd10);
      chk_gap = 1'b0;

      // flush during FRAME
      wd0 = wd_cnt;
      for (int i = 1; i <= 6; i++) put(12'h100 + 12'(i));
      bus.wr_valid = 1'b0;
      check("flush_pre_level", 32'(level), 32'd5);
      wait_frame();
      bus.flush = 1'b1;
      #1 check("flush_wr_ready", 32'(bus.wr_ready), 32'd0);
      @(negedge clk);
      bus.flush = 1'b0;
      expq.delete();
      check("flush_level", 32'(level), 32'd0);
      check("flush_busy", 32'(busy), 32'd1);
      drain("drain_flush");
      repeat (20) @(negedge clk);
      check("flush_word_done", 32'(wd_cnt - wd0), 32'd1);
      check("flush_newd", 32'(bus.newd), 32'd0);

      // async reset mid-frame
      wd0 = wd_cnt;
      put(12'h2AA);
      put(12'h2BB);
      bus.wr_valid = 1'b0;
      wait_frame();
      #2 rst = 1'b0;
      #1;
      check("arst_newd", 32'(bus.newd), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_level", 32'(level), 32'd0);
      expq.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      put(12'h3F0);
      bus.wr_valid = 1'b0;
      drain("drain_arst");
      check("arst_word_done", 32'(wd_cnt - wd0), 32'd1);
      check("arst_din", 32'(bus.din), 32'h3F0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, got timeout want finish");
      $fatal(1);
   end
endmodule

// File: doc/spi_tx_feeder.md
# spi_tx_feeder

Transmit-side buffer that sits directly upstream of the SPI master. It accepts 12-bit words from a producer over a valid/ready interface and stores them in a FIFO. It presents one word at a time to the master through `newd`/`din`. It paces words by watching the master's chip select: hold `newd` until the frame starts, wait for the frame to end, then insert an inter-frame gap.

## Interface
- `WIDTH`, 12, data word width; must match master `din`
- `DEPTH`, 8, FIFO depth in words; power of two, ≥2
- `GAP_CYCLES`, 4, `clk` cycles between `cs` rising and the next pop; 0 allowed
- `clk`  input  1  system clock, same clock driving the master
- `rst`  input  1  asynchronous, active-low reset; the top level inverts it for the active-high master reset
- `wr_valid`  input  1  producer has a word
- `wr_data`  input  WIDTH  producer word
- `wr_ready`  output  1  FIFO can accept; equals !full && !flush
- `flush`  input  1  synchronous clear of FIFO contents; the in-flight word is unaffected
- `cs_in`  input  1  master `cs` (active-low frame indicator)
- `newd`  output  1  new-data request to master
- `din`  output  WIDTH  word to master; stable while `newd`=1 and until `cs_in` rises
- `busy`  output  1  high in any state other than IDLE
- `level`  output  $clog2(DEPTH)+1  words currently stored (excludes in-flight word)
- `word_done`  output  1  one-cycle pulse when a frame completes

## Operation
- FIFO: circular buffer, read/write pointers with one extra wrap bit; full = pointers equal except wrap bit; empty = pointers equal.
- Write: `wr_valid && wr_ready` at a rising edge stores `wr_data` and increments `level`.
- `wr_ready` does not depend on same-cycle pop. When full, a write is refused even if a pop occurs that cycle.
- Simultaneous write and pop: `level` unchanged.
- `flush`=1: pointers reset, `level`←0. Flush has priority over a concurrent write, which is dropped (`wr_ready`=0).
- `cs_in` is registered once (`cs_q`) for edge detection. State decisions use the registered value.
- State machine:
  - IDLE: `newd`=0. If FIFO non-empty: pop, `din`←head word, `newd`←1, go to REQ.
  - REQ: hold `newd`=1 and `din`. When `cs_q`=0: `newd`←0, go to FRAME.
  - FRAME: wait for `cs_q`=1. Then `word_done` pulses for one cycle. Go to GAP, or to IDLE if `GAP_CYCLES`=0.
  - GAP: counter runs 0..`GAP_CYCLES`-1, then go to IDLE.
- `din` retains its last value in IDLE and GAP (no return to 0).
- `flush` in REQ/FRAME/GAP does not abort the in-flight word.
- Async reset at any time: state←IDLE, FIFO empty, all outputs to reset values immediately. A partially sent frame is abandoned.

## Timing
- Reset values: `newd`=0, `din`=0, `wr_ready`=1 (after `rst` deasserts, flush low), `busy`=0, `level`=0, `word_done`=0.
- Write into empty FIFO in IDLE at edge N:
  - `level`=1 after N.
  - Pop at edge N+1: `newd`=1, `din` valid, `level`=0.
- Master latches `newd` only on `sclk` rising. `newd` therefore stays high for up to ~2×11 `clk` periods plus the `cs_q` delay; no timeout.
- `newd` falls on the edge after `cs_q` is first seen 0.
- `word_done` asserts on the edge after `cs_q` is first seen 1.
- Next pop occurs GAP_CYCLES+1 edges after the `word_done` edge. `GAP_CYCLES`=0 gives 1 edge.
- Throughput: one word per master frame. The FIFO absorbs bursts up to `DEPTH` plus one in flight.

## Test plan
- Reset: hold `rst`=0 with `wr_valid`=1 → `newd`=0, `level`=0, `busy`=0, `din`=0. Release → first write lands and `newd` rises 2 edges later.
- Single word 0xA5C into empty FIFO, with master+slave attached → `newd` high until `cs` falls. Slave `dout`=0xA5C, `done` pulses, `word_done` pulses once.
- Burst of 9 writes (0x001..0x009) with `DEPTH`=8 and `wr_valid` held high:
  - First pops immediately; remaining eight fill the FIFO; then `wr_ready`=0 until the next pop.
  - Slave receives 0x001..0x009 in order.
  - Gap between `cs` rise and next `newd` rise = `GAP_CYCLES`+1 `clk`.
- Full FIFO with simultaneous pop and `wr_valid` → write refused, `level` 8→7. The next cycle accepts the write.
- Flush during FRAME with `level`=5 → `level`=0 next edge. The in-flight word completes with one `word_done`; no further `newd`.
- Async reset asserted mid-FRAME → `newd`/`busy`/`level` go to 0 without a clock edge. After release, new word 0x3F0 is delivered correctly once the master is also reset.
